instruction_prefetch_queue: RTL and testbench

- Parametrised successor of the single-shot fetch block: keeps a circular byte queue of code ahead of the decoder and fetches continuously over the code-bus valid/ready handshake while space is available.
- Supports unaligned branch targets, flush/redirect with an outstanding bus cycle, and partial consumption by the decoder.
- Sits between the bus interface unit (code port) and the instruction decoder.

---
 rtl/instruction_prefetch_queue_pkg.sv | 18 +
 rtl/prefetch_byte_ring.sv | 75 +++++++
 rtl/instruction_prefetch_queue.sv | 164 ++++++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_prefetch_queue_pkg.sv
// rtl/instruction_prefetch_queue_pkg.sv - shared state enum and pointer/address helpers for the prefetch queue
package instruction_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_FETCH,
        STATE_DISCARD
    } state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [31:0] align_address(input logic [31:0] address, input int bus_bytes);
        return address & ~(32'(bus_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/prefetch_byte_ring.sv
// rtl/prefetch_byte_ring.sv - circular byte store with skip-offset bus writes, clamped consume and window read-out
module prefetch_byte_ring
    import instruction_prefetch_queue_pkg::*;
#(
    parameter int QUEUE_BYTES  = 16,
    parameter int BUS_BYTES    = 4,
    parameter int WINDOW_BYTES = 16,
    localparam int PW  = ptr_width(QUEUE_BYTES),
    localparam int SW  = ptr_width(BUS_BYTES),
    localparam int CW  = $clog2(QUEUE_BYTES + 1),
    localparam int WCW = $clog2(BUS_BYTES + 1),
    localparam int RCW = $clog2(WINDOW_BYTES + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   wr_valid,
    input  logic [8*BUS_BYTES-1:0] wr_data,
    input  logic [SW-1:0]          wr_skip,
    input  logic [WCW-1:0]         wr_count,
    input  logic                   rd_valid,
    input  logic [RCW-1:0]         rd_count,
    output logic [7:0]             window [WINDOW_BYTES],
    output logic [CW-1:0]          count
);

    logic [7:0]    mem [QUEUE_BYTES];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] consumed;
    logic [CW-1:0] written;

    // The decoder may ask for more than is queued; retire only what exists.
    always_comb begin
        consumed = '0;
        if (rd_valid) begin
            consumed = (CW'(rd_count) < count) ? CW'(rd_count) : count;
        end
    end

    assign written = wr_valid ? CW'(wr_count) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(consumed);
            wr_ptr <= wr_ptr + PW'(written);
            count  <= count + written - consumed;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_valid && !clear) begin
            for (int i = 0; i < BUS_BYTES; i++) begin
                if (i >= int'(wr_skip) && (i - int'(wr_skip)) < int'(wr_count)) begin
                    mem[wr_ptr + PW'(i - int'(wr_skip))] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            window[i] = (CW'(i) < count) ? mem[rd_ptr + PW'(i)] : 8'h00;
        end
    end

endmodule

// File: rtl/instruction_prefetch_queue.sv
// rtl/instruction_prefetch_queue.sv - code-bus prefetch FSM feeding a byte ring; PREFETCH_LIMIT_CHECK_EN adds segment-limit faults
module instruction_prefetch_queue
    import instruction_prefetch_queue_pkg::*;
#(
    parameter int QUEUE_BYTES  = 16,
    parameter int BUS_BYTES    = 4,
    parameter int WINDOW_BYTES = 16
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    output logic                                 o_code_valid,
    input  logic                                 i_code_ready,
    output logic [31:0]                          o_code_address,
    input  logic [8*BUS_BYTES-1:0]               i_code_data_read,
    input  logic                                 i_flush,
    input  logic [31:0]                          i_flush_address,
    output logic [7:0]                           o_window [WINDOW_BYTES],
    output logic [$clog2(QUEUE_BYTES+1)-1:0]     o_window_count,
    input  logic                                 i_consume_valid,
    input  logic [$clog2(WINDOW_BYTES+1)-1:0]    i_consume_count
`ifdef PREFETCH_LIMIT_CHECK_EN
    ,
    input  logic [31:0]                          i_code_segment_limit,
    output logic                                 o_limit_fault
`endif
);

    localparam int SW  = ptr_width(BUS_BYTES);
    localparam int WCW = $clog2(BUS_BYTES + 1);

    state_t         state;
    logic [31:0]    fetch_ptr;
    logic           started;
    logic           fault;
    logic [31:0]    aligned_cur;
    logic [31:0]    next_address;
    logic [31:0]    flush_aligned;
    logic [SW-1:0]  skip;
    logic [WCW-1:0] wr_count;
    logic           over_flush;
    logic           over_cur;
    logic           over_next;
    logic           idle_space_ok;
    logic           next_space_ok;

    assign aligned_cur   = align_address(fetch_ptr, BUS_BYTES);
    assign next_address  = aligned_cur + 32'(BUS_BYTES);
    assign flush_aligned = align_address(i_flush_address, BUS_BYTES);
    assign skip          = fetch_ptr[SW-1:0];

`ifdef PREFETCH_LIMIT_CHECK_EN
    logic [31:0] limit_span;

    assign over_flush    = flush_aligned > i_code_segment_limit;
    assign over_cur      = aligned_cur > i_code_segment_limit;
    assign over_next     = next_address > i_code_segment_limit;
    assign limit_span    = i_code_segment_limit - aligned_cur;
    assign o_limit_fault = fault;

    // A straddling beat only contributes bytes at or below the limit.
    always_comb begin
        wr_count = WCW'(BUS_BYTES) - WCW'(skip);
        if (limit_span < 32'(BUS_BYTES - 1)) begin
            wr_count = (limit_span + 32'd1 > 32'(skip)) ? WCW'(limit_span + 32'd1 - 32'(skip)) : '0;
        end
    end
`else
    assign over_flush = 1'b0;
    assign over_cur   = 1'b0;
    assign over_next  = 1'b0;
    assign wr_count   = WCW'(BUS_BYTES) - WCW'(skip);
`endif

    // Space checks deliberately ignore same-cycle consumption.
    assign idle_space_ok = 32'(o_window_count) + 32'(BUS_BYTES) <= 32'(QUEUE_BYTES);
    assign next_space_ok = 32'(o_window_count) + 32'(wr_count) + 32'(BUS_BYTES) <= 32'(QUEUE_BYTES);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= STATE_IDLE;
            o_code_valid   <= 1'b0;
            o_code_address <= '0;
            fetch_ptr      <= '0;
            started        <= 1'b0;
            fault          <= 1'b0;
        end else if (i_flush) begin
            fetch_ptr <= i_flush_address;
            started   <= 1'b1;
            fault     <= 1'b0;
            if (o_code_valid && !i_code_ready) begin
                state <= STATE_DISCARD;
            end else if (over_flush) begin
                state        <= STATE_IDLE;
                o_code_valid <= 1'b0;
                fault        <= 1'b1;
            end else begin
                state          <= STATE_FETCH;
                o_code_valid   <= 1'b1;
                o_code_address <= flush_aligned;
            end
        end else begin
            unique case (state)
                STATE_IDLE: begin
                    if (started && !fault && idle_space_ok) begin
                        if (over_cur) begin
                            fault <= 1'b1;
                        end else begin
                            state          <= STATE_FETCH;
                            o_code_valid   <= 1'b1;
                            o_code_address <= aligned_cur;
                        end
                    end
                end
                STATE_FETCH: begin
                    if (i_code_ready) begin
                        fetch_ptr <= next_address;
                        if (next_space_ok && !over_next) begin
                            o_code_address <= next_address;
                        end else begin
                            state        <= STATE_IDLE;
                            o_code_valid <= 1'b0;
                            fault        <= next_space_ok;
                        end
                    end
                end
                STATE_DISCARD: begin
                    if (i_code_ready) begin
                        if (over_cur) begin
                            state        <= STATE_IDLE;
                            o_code_valid <= 1'b0;
                            fault        <= 1'b1;
                        end else begin
                            state          <= STATE_FETCH;
                            o_code_address <= aligned_cur;
                        end
                    end
                end
                default: begin
                    state        <= STATE_IDLE;
                    o_code_valid <= 1'b0;
                end
            endcase
        end
    end

    prefetch_byte_ring #(
        .QUEUE_BYTES (QUEUE_BYTES),
        .BUS_BYTES   (BUS_BYTES),
        .WINDOW_BYTES(WINDOW_BYTES)
    ) u_ring (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (i_flush),
        .wr_valid(state == STATE_FETCH && i_code_ready),
        .wr_data (i_code_data_read),
        .wr_skip (skip),
        .wr_count(wr_count),
        .rd_valid(i_consume_valid),
        .rd_count(i_consume_count),
        .window  (o_window),
        .count   (o_window_count)
    );

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// tb/tb_instruction_prefetch_queue.sv - directed self-checking bench for instruction_prefetch_queue
module tb_instruction_prefetch_queue;

    logic        clock;
    logic        reset_n;
    logic        o_code_valid;
    logic        i_code_ready;
    logic [31:0] o_code_address;
    logic [31:0] i_code_data_read;
    logic        i_flush;
    logic [31:0] i_flush_address;
    logic [7:0]  o_window [16];
    logic [4:0]  o_window_count;
    logic        i_consume_valid;
    logic [4:0]  i_consume_count;
`ifdef PREFETCH_LIMIT_CHECK_EN
    logic [31:0] i_code_segment_limit;
    logic        o_limit_fault;
`endif

    int checks = 0;
    int errors = 0;

    instruction_prefetch_queue dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .o_code_valid    (o_code_valid),
        .i_code_ready    (i_code_ready),
        .o_code_address  (o_code_address),
        .i_code_data_read(i_code_data_read),
        .i_flush         (i_flush),
        .i_flush_address (i_flush_address),
        .o_window        (o_window),
        .o_window_count  (o_window_count),
        .i_consume_valid (i_consume_valid),
        .i_consume_count (i_consume_count)
`ifdef PREFETCH_LIMIT_CHECK_EN
        ,
        .i_code_segment_limit(i_code_segment_limit),
        .o_limit_fault       (o_limit_fault)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory image: two fixed words for the unaligned test, otherwise byte = addr[7:0] + 0x10 + lane.
    function automatic logic [31:0] bus_word(input logic [31:0] address);
        logic [31:0] word;
        if (address == 32'h0000_2000) begin
            word = 32'h4433_2211;
        end else if (address == 32'h0000_2004) begin
            word = 32'h8877_6655;
        end else begin
            for (int k = 0; k < 4; k++) begin
                word[8*k +: 8] = address[7:0] + 8'h10 + 8'(k);
            end
        end
        return word;
    endfunction

    assign i_code_data_read = bus_word(o_code_address);

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n         = 1'b0;
        i_code_ready    = 1'b0;
        i_flush         = 1'b0;
        i_flush_address = '0;
        i_consume_valid = 1'b0;
        i_consume_count = '0;
`ifdef PREFETCH_LIMIT_CHECK_EN
        i_code_segment_limit = 32'hFFFF_FFFF;
`endif
        #2;
        check_value("rst_valid", 32'(o_code_valid), 32'd0);
        check_value("rst_addr", o_code_address, 32'd0);
        check_value("rst_count", 32'(o_window_count), 32'd0);
        check_value("rst_win0", 32'(o_window[0]), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check_value("no_fetch_before_flush", 32'(o_code_valid), 32'd0);

        // Back-to-back fill from 0x1000 with ready held high.
        i_flush = 1'b1; i_flush_address = 32'h0000_1000; i_code_ready = 1'b1;
        tick();
        i_flush = 1'b0;
        check_value("fill_valid0", 32'(o_code_valid), 32'd1);
        check_value("fill_addr0", o_code_address, 32'h0000_1000);
        tick();
        check_value("fill_addr1", o_code_address, 32'h0000_1004);
        check_value("fill_count1", 32'(o_window_count), 32'd4);
        tick();
        check_value("fill_addr2", o_code_address, 32'h0000_1008);
        tick();
        check_value("fill_addr3", o_code_address, 32'h0000_100C);
        check_value("fill_count3", 32'(o_window_count), 32'd12);
        tick();
        check_value("full_count", 32'(o_window_count), 32'd16);
        check_value("full_valid", 32'(o_code_valid), 32'd0);
        check_value("full_win0", 32'(o_window[0]), 32'h10);
        check_value("full_win15", 32'(o_window[15]), 32'h1F);
        tick();
        check_value("full_hold_valid", 32'(o_code_valid), 32'd0);

        // Partial consume: free space 3 is not enough for a beat.
        i_consume_valid = 1'b1; i_consume_count = 5'd3;
        tick();
        check_value("cons3_count", 32'(o_window_count), 32'd13);
        check_value("cons3_valid", 32'(o_code_valid), 32'd0);
        check_value("cons3_win0", 32'(o_window[0]), 32'h13);
        i_consume_count = 5'd1;
        tick();
        i_consume_valid = 1'b0;
        check_value("cons1_count", 32'(o_window_count), 32'd12);
        check_value("cons1_valid", 32'(o_code_valid), 32'd0);
        tick();
        check_value("refill_valid", 32'(o_code_valid), 32'd1);
        check_value("refill_addr", o_code_address, 32'h0000_1010);
        tick();
        check_value("refill_count", 32'(o_window_count), 32'd16);
        check_value("refill_win0", 32'(o_window[0]), 32'h14);
        check_value("refill_win15", 32'(o_window[15]), 32'h23);
        check_value("refill_idle", 32'(o_code_valid), 32'd0);

        // Unaligned branch target 0x2003.
        i_flush = 1'b1; i_flush_address = 32'h0000_2003;
        tick();
        i_flush = 1'b0;
        check_value("unal_addr0", o_code_address, 32'h0000_2000);
        check_value("unal_count0", 32'(o_window_count), 32'd0);
        tick();
        check_value("unal_count1", 32'(o_window_count), 32'd1);
        check_value("unal_addr1", o_code_address, 32'h0000_2004);
        tick();
        i_code_ready = 1'b0;
        check_value("unal_count", 32'(o_window_count), 32'd5);
        check_value("unal_w0", 32'(o_window[0]), 32'h44);
        check_value("unal_w1", 32'(o_window[1]), 32'h55);
        check_value("unal_w2", 32'(o_window[2]), 32'h66);
        check_value("unal_w3", 32'(o_window[3]), 32'h77);
        check_value("unal_w4", 32'(o_window[4]), 32'h88);
        check_value("unal_w5", 32'(o_window[5]), 32'h00);
        check_value("unal_pending", o_code_address, 32'h0000_2008);

        // Flush while the 0x2008 request is still waiting for ready.
        i_flush = 1'b1; i_flush_address = 32'h0000_3000;
        tick();
        i_flush = 1'b0;
        check_value("disc_valid", 32'(o_code_valid), 32'd1);
        check_value("disc_old_addr", o_code_address, 32'h0000_2008);
        check_value("disc_count", 32'(o_window_count), 32'd0);
        tick();
        tick();
        check_value("disc_hold_addr", o_code_address, 32'h0000_2008);
        i_code_ready = 1'b1;
        tick();
        i_code_ready = 1'b0;
        check_value("disc_dropped", 32'(o_window_count), 32'd0);
        check_value("disc_new_addr", o_code_address, 32'h0000_3000);
        tick();
        check_value("disc_new_hold", o_code_address, 32'h0000_3000);

        // Flush beats a same-cycle write and consume.
        i_code_ready = 1'b1;
        tick();
        check_value("pre_flush_count", 32'(o_window_count), 32'd4);
        i_consume_valid = 1'b1; i_consume_count = 5'd4;
        i_flush = 1'b1; i_flush_address = 32'h0000_4001;
        tick();
        i_flush = 1'b0; i_consume_valid = 1'b0; i_code_ready = 1'b0;
        check_value("prio_count", 32'(o_window_count), 32'd0);
        check_value("prio_addr", o_code_address, 32'h0000_4000);
        check_value("prio_win0", 32'(o_window[0]), 32'h00);
        i_code_ready = 1'b1;
        tick();
        i_code_ready = 1'b0;
        check_value("skip1_count", 32'(o_window_count), 32'd3);
        check_value("skip1_win0", 32'(o_window[0]), 32'h11);
        check_value("skip1_win2", 32'(o_window[2]), 32'h13);

        // Consume larger than the queue is clamped.
        i_consume_valid = 1'b1; i_consume_count = 5'd7;
        tick();
        i_consume_valid = 1'b0;
        check_value("clamp_count", 32'(o_window_count), 32'd0);
        check_value("clamp_win0", 32'(o_window[0]), 32'h00);

        // 32-bit fetch pointer wrap.
        i_flush = 1'b1; i_flush_address = 32'hFFFF_FFFE; i_code_ready = 1'b1;
        tick();
        i_flush = 1'b0;
        check_value("wrap_addr0", o_code_address, 32'hFFFF_FFFC);
        tick();
        i_code_ready = 1'b0;
        check_value("wrap_addr1", o_code_address, 32'h0000_0000);
        check_value("wrap_count", 32'(o_window_count), 32'd2);
        check_value("wrap_win0", 32'(o_window[0]), 32'h0E);
        check_value("wrap_win1", 32'(o_window[1]), 32'h0F);

        // Asynchronous reset with a request outstanding.
        #2;
        reset_n = 1'b0;
        #1;
        check_value("arst_valid", 32'(o_code_valid), 32'd0);
        check_value("arst_addr", o_code_address, 32'd0);
        check_value("arst_count", 32'(o_window_count), 32'd0);
        i_code_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check_value("arst_late_ready_valid", 32'(o_code_valid), 32'd0);
        check_value("arst_late_ready_count", 32'(o_window_count), 32'd0);

`ifdef PREFETCH_LIMIT_CHECK_EN
        i_code_segment_limit = 32'h0000_1007;
        i_flush = 1'b1; i_flush_address = 32'h0000_1000;
        tick();
        i_flush = 1'b0;
        check_value("lim_addr0", o_code_address, 32'h0000_1000);
        tick();
        check_value("lim_addr1", o_code_address, 32'h0000_1004);
        tick();
        check_value("lim_fault", 32'(o_limit_fault), 32'd1);
        check_value("lim_count", 32'(o_window_count), 32'd8);
        check_value("lim_valid", 32'(o_code_valid), 32'd0);
        i_code_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
